// File: rtl/regfile_mp_if.sv
// Register file access bundle: one write port, two read ports, scrub control/status.
// Latency: none (wires only); timing is defined by the register file attached as slave.
// Backpressure: none; rejected writes are reported through wr_err instead of stalling.
// Ports: we/wa/wd write; a1/a2 -> rd1/v1, rd2/v2 reads; clr_req -> clr_busy/clr_done; wr_err.
interface regfile_mp_if #(
  parameter int DATA_W = 8,
  parameter int AW     = 3
);
  logic              we;
  logic [AW-1:0]     wa;
  logic [DATA_W-1:0] wd;
  logic [AW-1:0]     a1;
  logic [AW-1:0]     a2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              v1;
  logic              v2;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;
  logic              wr_err;

  modport master (
    output we, wa, wd, a1, a2, clr_req,
    input  rd1, rd2, v1, v2, clr_busy, clr_done, wr_err
  );

  modport slave (
    input  we, wa, wd, a1, a2, clr_req,
    output rd1, rd2, v1, v2, clr_busy, clr_done, wr_err
  );
endinterface

// File: rtl/regfile_mp.sv
// Register file for the encryptor datapath (keys, round state, scratch) with valid bits and a scrub engine.
// Latency: reads combinational (REG_READ=0) or 1 cycle (REG_READ=1); writes commit on the edge.
// Backpressure: none; writes during a scrub or to an out-of-range address are dropped and flagged on wr_err.
// Ports: clk, rst_n (async active-low); bus (regfile_mp_if.slave): we/wa/wd, a1/a2 -> rd/v, clr_req/clr_busy/clr_done, wr_err.
module regfile_mp #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int REG_READ = 0,
  parameter int BYPASS   = 1,
  parameter int ZERO_R0  = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // One extra bit so the range check also works for power-of-two depths.
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wr_err_q, wr_err_d;

  logic                wa_ok;
  logic                wr_drop0;
  logic                wr_acc;
  logic [AW-1:0]       ra   [2];
  logic [DATA_W-1:0]   rd_d [2];
  logic                v_d  [2];

  assign ra[0] = bus.a1;
  assign ra[1] = bus.a2;

  assign wa_ok    = ({1'b0, bus.wa} < DEPTH_W);
  // Writes to a hardwired-zero entry vanish silently: not an error, just no effect.
  assign wr_drop0 = (ZERO_R0 != 0) && (bus.wa == '0);
  assign wr_acc   = bus.we && (state_q == ST_IDLE) && wa_ok && !wr_drop0;

  // Next-state array, valid bits and scrub sequencer.
  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    state_d  = state_q;
    ptr_d    = ptr_q;
    wr_err_d = bus.we && ((state_q != ST_IDLE) || !wa_ok);

    // A write in the same IDLE cycle as clr_req still lands; the scrub erases it afterwards.
    if (wr_acc) begin
      mem_d[bus.wa]   = bus.wd;
      valid_d[bus.wa] = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.clr_req) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        mem_d[ptr_q]   = '0;
        valid_d[ptr_q] = 1'b0;
        if (ptr_q == PTR_LAST) begin
          ptr_d   = '0;
          state_d = ST_DONE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Read ports. The registered variant samples next-state contents, so it sees the
  // write and scrub of the same edge regardless of BYPASS; the combinational variant
  // only forwards wd when BYPASS is set.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_d[p] = '0;
      v_d[p]  = 1'b0;
      if ({1'b0, ra[p]} < DEPTH_W) begin
        if ((ZERO_R0 != 0) && (ra[p] == '0)) begin
          v_d[p] = 1'b1;
        end else if (REG_READ != 0) begin
          rd_d[p] = mem_d[ra[p]];
          v_d[p]  = valid_d[ra[p]];
        end else if ((BYPASS != 0) && wr_acc && (bus.wa == ra[p])) begin
          rd_d[p] = bus.wd;
          v_d[p]  = 1'b1;
        end else begin
          rd_d[p] = mem_q[ra[p]];
          v_d[p]  = valid_q[ra[p]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      valid_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign bus.clr_busy = busy_q;
  assign bus.clr_done = done_q;
  assign bus.wr_err   = wr_err_q;

  generate
    if (REG_READ != 0) begin : g_reg_read
      logic [DATA_W-1:0] rd1_q, rd2_q;
      logic              v1_q, v2_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd1_q <= '0;
          rd2_q <= '0;
          v1_q  <= 1'b0;
          v2_q  <= 1'b0;
        end else begin
          rd1_q <= rd_d[0];
          rd2_q <= rd_d[1];
          v1_q  <= v_d[0];
          v2_q  <= v_d[1];
        end
      end

      assign bus.rd1 = rd1_q;
      assign bus.rd2 = rd2_q;
      assign bus.v1  = v1_q;
      assign bus.v2  = v2_q;
    end else begin : g_comb_read
      assign bus.rd1 = rd_d[0];
      assign bus.rd2 = rd_d[1];
      assign bus.v1  = v_d[0];
      assign bus.v2  = v_d[1];
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       we;
  logic [2:0] wa;
  logic [7:0] wd;
  logic [2:0] a1;
  logic [2:0] a2;
  logic       clr_req;

  always #5 clk = ~clk;

  // Four configurations share the stimulus:
  // 0: 8 deep, comb, bypass   1: 8 deep, registered   2: 8 deep, comb, no bypass
  // 3: 6 deep, comb, bypass, entry 0 hardwired to zero
  logic [7:0] o_rd1 [4];
  logic [7:0] o_rd2 [4];
  logic       o_v1  [4];
  logic       o_v2  [4];
  logic       o_busy[4];
  logic       o_done[4];
  logic       o_err [4];

  for (genvar g = 0; g < 4; g++) begin : gd
    regfile_mp_if #(.DATA_W(8), .AW(3)) bus ();
    assign bus.we      = we;
    assign bus.wa      = wa;
    assign bus.wd      = wd;
    assign bus.a1      = a1;
    assign bus.a2      = a2;
    assign bus.clr_req = clr_req;

    regfile_mp #(
      .DATA_W  (8),
      .DEPTH   ((g == 3) ? 6 : 8),
      .REG_READ((g == 1) ? 1 : 0),
      .BYPASS  ((g == 2) ? 0 : 1),
      .ZERO_R0 ((g == 3) ? 1 : 0)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );

    assign o_rd1[g]  = bus.rd1;
    assign o_rd2[g]  = bus.rd2;
    assign o_v1[g]   = bus.v1;
    assign o_v2[g]   = bus.v2;
    assign o_busy[g] = bus.clr_busy;
    assign o_done[g] = bus.clr_done;
    assign o_err[g]  = bus.wr_err;
  end

  function automatic int cfg_depth(input int d); return (d == 3) ? 6 : 8; endfunction
  function automatic bit cfg_rr(input int d);    return d == 1;           endfunction
  function automatic bit cfg_byp(input int d);   return d != 2;           endfunction
  function automatic bit cfg_zr(input int d);    return d == 3;           endfunction

  // Reference model: contents, valid flags and "cycles into the scrub"
  // (0 = idle, 1..DEPTH = wiping entry n-1, DEPTH+1 = completion cycle).
  logic [7:0] m_mem [4][8];
  bit         m_vld [4][8];
  int         m_ph  [4];
  logic [7:0] e_rd1 [4];
  logic [7:0] e_rd2 [4];
  bit         e_v1  [4];
  bit         e_v2  [4];
  bit         e_busy[4];
  bit         e_done[4];
  bit         e_err [4];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", nm, d, act, exp, $time);
    end
  endtask

  function automatic bit accepted(input int d);
    return we && (m_ph[d] == 0) && (int'(wa) < cfg_depth(d)) && !(cfg_zr(d) && wa == 3'd0);
  endfunction

  function automatic void rd_exp(input int d, input int a, input bit comb,
                                 output logic [7:0] r, output bit v);
    r = 8'h00;
    v = 1'b0;
    if (a < cfg_depth(d)) begin
      if (cfg_zr(d) && a == 0) begin
        v = 1'b1;
      end else if (comb && cfg_byp(d) && accepted(d) && int'(wa) == a) begin
        r = wd;
        v = 1'b1;
      end else begin
        r = m_mem[d][a];
        v = m_vld[d][a];
      end
    end
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 8; i++) begin
        m_mem[d][i] = 8'h00;
        m_vld[d][i] = 1'b0;
      end
      m_ph[d]   = 0;
      e_rd1[d]  = 8'h00;
      e_rd2[d]  = 8'h00;
      e_v1[d]   = 1'b0;
      e_v2[d]   = 1'b0;
      e_busy[d] = 1'b0;
      e_done[d] = 1'b0;
      e_err[d]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    int D;
    for (int d = 0; d < 4; d++) begin
      D = cfg_depth(d);
      e_err[d] = we && ((m_ph[d] != 0) || (int'(wa) >= D));
      if (accepted(d)) begin
        m_mem[d][wa] = wd;
        m_vld[d][wa] = 1'b1;
      end
      if (m_ph[d] == 0) begin
        if (clr_req) m_ph[d] = 1;
      end else if (m_ph[d] <= D) begin
        m_mem[d][m_ph[d]-1] = 8'h00;
        m_vld[d][m_ph[d]-1] = 1'b0;
        m_ph[d]++;
      end else begin
        m_ph[d] = 0;
      end
      e_busy[d] = (m_ph[d] != 0);
      e_done[d] = (m_ph[d] == D + 1);
      rd_exp(d, int'(a1), 1'b0, e_rd1[d], e_v1[d]);
      rd_exp(d, int'(a2), 1'b0, e_rd2[d], e_v2[d]);
    end
  endtask

  // Called just after a falling edge with inputs already applied: checks the
  // combinational ports, advances the model, clocks, then checks registered outputs.
  task automatic step();
    logic [7:0] r;
    bit         v;
    #1;
    for (int d = 0; d < 4; d++) begin
      if (!cfg_rr(d)) begin
        rd_exp(d, int'(a1), 1'b1, r, v);
        chk("rd1", d, 32'(o_rd1[d]), 32'(r));
        chk("v1",  d, 32'(o_v1[d]),  32'(v));
        rd_exp(d, int'(a2), 1'b1, r, v);
        chk("rd2", d, 32'(o_rd2[d]), 32'(r));
        chk("v2",  d, 32'(o_v2[d]),  32'(v));
      end
    end
    model_edge();
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk("clr_busy", d, 32'(o_busy[d]), 32'(e_busy[d]));
      chk("clr_done", d, 32'(o_done[d]), 32'(e_done[d]));
      chk("wr_err",   d, 32'(o_err[d]),  32'(e_err[d]));
      if (cfg_rr(d)) begin
        chk("rd1_reg", d, 32'(o_rd1[d]), 32'(e_rd1[d]));
        chk("v1_reg",  d, 32'(o_v1[d]),  32'(e_v1[d]));
        chk("rd2_reg", d, 32'(o_rd2[d]), 32'(e_rd2[d]));
        chk("v2_reg",  d, 32'(o_v2[d]),  32'(e_v2[d]));
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit         we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] a1;
    logic [2:0] a2;
    logic [7:0] rd1;
    logic [7:0] rd2;
    bit         v1;
    bit         v2;
    logic [7:0] nb_rd1;   // port 1 of the no-bypass file, same cycle
    logic [7:0] reg_rd1;  // port 1 of the registered file, after the edge
  } vec_t;

  initial begin
    vec_t tbl [7];
    int   busy_cnt;
    int   done_cnt;
    int   guard;

    tbl[0] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd7, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[1] = '{1'b1, 3'd5, 8'hAA, 3'd5, 3'd2, 8'hAA, 8'h00, 1'b1, 1'b0, 8'h00, 8'hAA};
    tbl[2] = '{1'b1, 3'd2, 8'h55, 3'd5, 3'd2, 8'hAA, 8'h55, 1'b1, 1'b1, 8'hAA, 8'hAA};
    tbl[3] = '{1'b0, 3'd0, 8'h00, 3'd5, 3'd2, 8'hAA, 8'h55, 1'b1, 1'b1, 8'hAA, 8'hAA};
    tbl[4] = '{1'b1, 3'd3, 8'h3C, 3'd3, 3'd3, 8'h3C, 8'h3C, 1'b1, 1'b1, 8'h00, 8'h3C};
    tbl[5] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd4, 8'h3C, 8'h00, 1'b1, 1'b0, 8'h3C, 8'h3C};
    tbl[6] = '{1'b1, 3'd3, 8'h11, 3'd3, 3'd5, 8'h11, 8'hAA, 1'b1, 1'b1, 8'h3C, 8'h11};

    rst_n = 1'b0; we = 1'b0; wa = 3'd0; wd = 8'h00; a1 = 3'd0; a2 = 3'd0; clr_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk("reset_busy", d, 32'(o_busy[d]), 32'd0);
      chk("reset_done", d, 32'(o_done[d]), 32'd0);
      chk("reset_err",  d, 32'(o_err[d]),  32'd0);
    end
    chk("reset_rd1_reg", 1, 32'(o_rd1[1]), 32'd0);
    chk("reset_v1_reg",  1, 32'(o_v1[1]),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Every address reads empty after reset.
    for (int a = 0; a < 8; a++) begin
      a1 = 3'(a);
      a2 = 3'(7 - a);
      step();
    end

    // Directed write/read/bypass vectors.
    for (int i = 0; i < 7; i++) begin
      we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd; a1 = tbl[i].a1; a2 = tbl[i].a2;
      #1;
      chk("tbl_rd1",    0, 32'(o_rd1[0]), 32'(tbl[i].rd1));
      chk("tbl_rd2",    0, 32'(o_rd2[0]), 32'(tbl[i].rd2));
      chk("tbl_v1",     0, 32'(o_v1[0]),  32'(tbl[i].v1));
      chk("tbl_v2",     0, 32'(o_v2[0]),  32'(tbl[i].v2));
      chk("tbl_nb_rd1", 2, 32'(o_rd1[2]), 32'(tbl[i].nb_rd1));
      step();
      chk("tbl_reg_rd1", 1, 32'(o_rd1[1]), 32'(tbl[i].reg_rd1));
    end

    // Fill every entry, then scrub: 8 CLEAR cycles + 1 DONE cycle of busy.
    for (int a = 0; a < 8; a++) begin
      we = 1'b1; wa = 3'(a); wd = 8'($urandom_range(1, 255)); a1 = 3'(a); a2 = 3'(a);
      step();
    end
    we = 1'b0; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_busy[0]) busy_cnt++;
      if (o_done[0]) done_cnt++;
      a1 = 3'($urandom_range(0, 7));
      a2 = 3'($urandom_range(0, 7));
      step();
    end
    chk("scrub_busy_cycles", 0, 32'(busy_cnt), 32'd9);
    chk("scrub_done_pulses", 0, 32'(done_cnt), 32'd1);
    for (int a = 0; a < 8; a++) begin
      a1 = 3'(a);
      a2 = 3'(a);
      #1;
      chk("post_scrub_v1",  0, 32'(o_v1[0]),  32'd0);
      chk("post_scrub_rd1", 0, 32'(o_rd1[0]), 32'd0);
      step();
    end

    // Write during CLEAR is rejected and flagged on the next cycle.
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    we = 1'b1; wa = 3'd4; wd = 8'h77;
    step();
    we = 1'b0;
    chk("clear_write_err", 0, 32'(o_err[0]), 32'd1);
    guard = 0;
    while (o_busy[0] && guard < 20) begin
      step();
      guard++;
    end
    chk("scrub_finished", 0, 32'(o_busy[0]), 32'd0);
    a1 = 3'd4;
    #1;
    chk("clear_write_rd", 0, 32'(o_rd1[0]), 32'd0);
    chk("clear_write_v",  0, 32'(o_v1[0]),  32'd0);
    step();

    // Out-of-range write on the 6-deep file.
    we = 1'b1; wa = 3'd7; wd = 8'h99; a1 = 3'd7; a2 = 3'd6;
    step();
    we = 1'b0;
    chk("oor_write_err", 3, 32'(o_err[3]), 32'd1);
    #1;
    chk("oor_read_rd", 3, 32'(o_rd1[3]), 32'd0);
    chk("oor_read_v",  3, 32'(o_v1[3]),  32'd0);
    step();

    // Reset in the middle of a scrub (pointer at 3).
    for (int a = 0; a < 8; a++) begin
      we = 1'b1; wa = 3'(a); wd = 8'(8'h40 + a); a1 = 3'd6; a2 = 3'd7;
      step();
    end
    we = 1'b0; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      chk("midscrub_rst_busy", d, 32'(o_busy[d]), 32'd0);
      chk("midscrub_rst_done", d, 32'(o_done[d]), 32'd0);
    end
    chk("midscrub_rst_v1",     0, 32'(o_v1[0]),  32'd0);
    chk("midscrub_rst_rd1",    0, 32'(o_rd1[0]), 32'd0);
    chk("midscrub_rst_v1_reg", 1, 32'(o_v1[1]),  32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step();
    we = 1'b1; wa = 3'd2; wd = 8'h5A; a1 = 3'd2; a2 = 3'd1;
    step();
    we = 1'b0;
    chk("after_rst_write_err", 0, 32'(o_err[0]), 32'd0);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      we      = 1'($urandom_range(0, 1));
      wa      = 3'($urandom_range(0, 7));
      wd      = 8'($urandom);
      a1      = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      a2      = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      clr_req = ($urandom_range(0, 24) == 0);
      step();
    end
    clr_req = 1'b0;
    we      = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
